// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, drives BRAM port A (1-cycle read latency)
// and registers returned words into the IR that feeds the decoder, with stall/redirect.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] instr_pc,
    output logic [15:0] pc_plus1
);

    logic [15:0] pc_q,       pc_d;
    logic        f_valid_q,  f_valid_d;
    logic [15:0] f_pc_q,     f_pc_d;
    logic [15:0] ir_q,       ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic [15:0] ir_pc_q,    ir_pc_d;

    // Default is hold; redirect squashes both the in-flight word and the IR.
    always_comb begin
        pc_d       = pc_q;
        f_valid_d  = f_valid_q;
        f_pc_d     = f_pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        ir_pc_d    = ir_pc_q;
        if (redirect) begin
            pc_d       = redirect_pc;
            f_valid_d  = 1'b0;
            ir_d       = 16'h0000;
            ir_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d       = pc_q + 16'd1;
            f_valid_d  = 1'b1;
            f_pc_d     = pc_q;
            ir_d       = f_valid_q ? mem_rdata : 16'h0000;
            ir_valid_d = f_valid_q;
            ir_pc_d    = f_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            f_valid_q  <= 1'b0;
            f_pc_q     <= 16'h0000;
            ir_q       <= 16'h0000;
            ir_valid_q <= 1'b0;
            ir_pc_q    <= 16'h0000;
        end else begin
            pc_q       <= pc_d;
            f_valid_q  <= f_valid_d;
            f_pc_q     <= f_pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            ir_pc_q    <= ir_pc_d;
        end
    end

    // Dropping the enable during a stall keeps mem_rdata frozen, so no word is lost.
    assign mem_en      = ~stall | redirect | reset;
    assign mem_addr    = pc_q;
    assign instr       = ir_valid_q ? ir_q : 16'h0000;
    assign instr_valid = ir_valid_q;
    assign instr_pc    = ir_pc_q;
    assign pc_plus1    = ir_pc_q + 16'd1;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised and directed bench for instr_fetch with a BRAM model and an
// address-level reference model of the two-deep fetch pipeline.
module tb_instr_fetch;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [15:0] redirect_pc;
    logic [15:0] mem_addr, mem_rdata, instr, instr_pc, pc_plus1;
    logic        mem_en, instr_valid;

    logic [15:0] mem [0:65535];
    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .mem_addr(mem_addr), .mem_en(mem_en),
        .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
        .instr_pc(instr_pc), .pc_plus1(pc_plus1)
    );

    always #5 clk = ~clk;

    // BRAM port A: 1-cycle synchronous read, output held while disabled.
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    // Reference model: each pipeline slot carries the address it was fetched from.
    typedef struct { bit v; logic [15:0] a; } slot_t;
    slot_t       m_fly, m_ir;
    logic [15:0] m_pc;

    function automatic void model_edge();
        if (reset) begin
            m_pc = RESET_PC; m_fly = '{1'b0, 16'h0}; m_ir = '{1'b0, 16'h0};
        end else if (redirect) begin
            m_pc = redirect_pc; m_fly.v = 1'b0; m_ir.v = 1'b0;
        end else if (!stall) begin
            m_ir = m_fly; m_fly = '{1'b1, m_pc}; m_pc = m_pc + 16'd1;
        end
    endfunction

    // {instr, instr_valid, instr_pc, pc_plus1, mem_addr}
    function automatic logic [64:0] exp_out();
        logic [15:0] d;
        d = m_ir.v ? mem[m_ir.a] : 16'h0000;
        return {d, m_ir.v, m_ir.a, m_ir.a + 16'd1, m_pc};
    endfunction

    function automatic logic [64:0] act_out();
        return {instr, instr_valid, instr_pc, pc_plus1, mem_addr};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic r, input logic s, input logic d, input logic [15:0] p);
        reset = r; stall = s; redirect = d; redirect_pc = p;
    endtask

    task automatic do_reset();
        set_in(1, 0, 0, 16'h0); cyc(); set_in(0, 0, 0, 16'h0);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({instr, instr_valid, instr_pc, pc_plus1, mem_addr, mem_en} !== {16'h0, 1'b0, 16'h0, 16'h1, RESET_PC, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values got %h want %h", {instr, instr_valid, instr_pc, pc_plus1, mem_addr, mem_en},
                     {16'h0, 1'b0, 16'h0, 16'h1, RESET_PC, 1'b1});
        end
    endtask

    task automatic test_straight();
        do_reset();
        cyc();
        n_tests++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL straight_edge1_bubble got %b want 0", instr_valid); end
        for (int e = 0; e < 5; e++) begin
            cyc();
            n_tests++;
            if ({instr, instr_valid, instr_pc} !== {16'h5000 + 16'(e), 1'b1, 16'(e)}) begin
                n_fail++;
                $display("FAIL straight_word%0d got %h want %h", e, {instr, instr_valid, instr_pc}, {16'h5000 + 16'(e), 1'b1, 16'(e)});
            end
        end
    endtask

    // Continues from test_straight: IR holds 5004 and the PC is 6.
    task automatic test_stall();
        set_in(0, 1, 0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++;
            if ({instr, instr_valid, mem_addr, mem_en} !== {16'h5004, 1'b1, 16'h0006, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold%0d got %h want %h", i, {instr, instr_valid, mem_addr, mem_en}, {16'h5004, 1'b1, 16'h0006, 1'b0});
            end
        end
        set_in(0, 0, 0, 16'h0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_tests++;
            if ({instr, instr_pc} !== {16'h5005 + 16'(i), 16'h0005 + 16'(i)}) begin
                n_fail++;
                $display("FAIL stall_resume%0d got %h want %h", i, {instr, instr_pc}, {16'h5005 + 16'(i), 16'h0005 + 16'(i)});
            end
        end
    endtask

    task automatic redirect_case(input logic s, input logic [15:0] tgt, input logic [15:0] want);
        do_reset();
        repeat (4) cyc();
        set_in(0, s, 1, tgt);
        cyc();
        set_in(0, 0, 0, 16'h0);
        n_tests++;
        if (mem_addr !== tgt) begin n_fail++; $display("FAIL redir_addr got %h want %h", mem_addr, tgt); end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({instr, instr_valid} !== {16'h0, 1'b0}) begin
                n_fail++; $display("FAIL redir_bubble%0d got %h want 0", i, {instr, instr_valid});
            end
            cyc();
        end
        n_tests++;
        if ({instr, instr_valid, instr_pc, pc_plus1} !== {want, 1'b1, tgt, tgt + 16'd1}) begin
            n_fail++;
            $display("FAIL redir_target got %h want %h", {instr, instr_valid, instr_pc, pc_plus1}, {want, 1'b1, tgt, tgt + 16'd1});
        end
    endtask

    task automatic test_redirect();
        mem[16'h0100] = 16'hA1B2;
        redirect_case(1'b0, 16'h0100, 16'hA1B2);
    endtask

    task automatic test_redirect_stall();
        redirect_case(1'b1, 16'h0020, 16'h5020);
    endtask

    task automatic test_wrap();
        logic [15:0] ipc [3];
        logic [15:0] idat [3];
        ipc  = '{16'hFFFE, 16'hFFFF, 16'h0000};
        idat = '{16'h0001, 16'h0002, 16'h0003};
        mem[16'hFFFE] = 16'h0001; mem[16'hFFFF] = 16'h0002; mem[16'h0000] = 16'h0003;
        do_reset();
        set_in(0, 0, 1, 16'hFFFE); cyc(); set_in(0, 0, 0, 16'h0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++;
            if ({instr, instr_valid, instr_pc, pc_plus1} !== {idat[i], 1'b1, ipc[i], ipc[i] + 16'd1}) begin
                n_fail++;
                $display("FAIL wrap%0d got %h want %h", i, {instr, instr_valid, instr_pc, pc_plus1}, {idat[i], 1'b1, ipc[i], ipc[i] + 16'd1});
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        repeat (4) cyc();
        set_in(0, 1, 0, 16'h0); cyc();
        set_in(1, 1, 0, 16'h0); cyc();
        n_tests++;
        if ({instr, instr_valid, mem_addr} !== {16'h0, 1'b0, RESET_PC}) begin
            n_fail++; $display("FAIL rst_stall got %h want %h", {instr, instr_valid, mem_addr}, {16'h0, 1'b0, RESET_PC});
        end
        set_in(0, 0, 0, 16'h0);
        cyc();
        n_tests++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_refill1 got %b want 0", instr_valid); end
        cyc();
        n_tests++;
        if ({instr, instr_valid, instr_pc} !== {mem[RESET_PC], 1'b1, RESET_PC}) begin
            n_fail++; $display("FAIL rst_refill2 got %h want %h", {instr, instr_valid, instr_pc}, {mem[RESET_PC], 1'b1, RESET_PC});
        end
    endtask

    task automatic test_random();
        logic r, s, d;
        for (int i = 0; i < 2000; i++) mem[$urandom_range(65535, 0)] = 16'($urandom);
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(99, 0) < 2);
            s = ($urandom_range(99, 0) < 30);
            d = ($urandom_range(99, 0) < 10);
            set_in(r, s, d, ($urandom_range(3, 0) == 0) ? 16'hFFFD + 16'($urandom_range(3, 0)) : 16'($urandom));
            #1;
            n_tests++;
            if (mem_en !== (~s | d | r)) begin
                n_fail++; $display("FAIL rand_mem_en cyc %0d got %b want %b", i, mem_en, ~s | d | r);
            end
            cyc();
            n_tests++;
            if (act_out() !== exp_out()) begin
                n_fail++; $display("FAIL rand_out cyc %0d got %h want %h", i, act_out(), exp_out());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h5000 + 16'(i);
        set_in(1, 0, 0, 16'h0);
        m_pc = RESET_PC; m_fly = '{1'b0, 16'h0}; m_ir = '{1'b0, 16'h0};
        test_reset();
        test_straight();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of `decoder`. Holds the program counter and issues word addresses to BRAM port A, which has 1-cycle synchronous read latency. Returned words are registered into the instruction register (IR), whose output feeds `decoder.instr`. The stage supports pipeline stall and branch/jump redirect, and inserts NOP (16'h0000) bubbles whenever no valid word is available.

## Interface
- `RESET_PC`, 16'h0000, word address fetched first after reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold request from downstream; freezes PC, IR and the BRAM output.
- `redirect`  in  1  taken branch/jump this cycle; has priority over `stall`.
- `redirect_pc`  in  16  target word address, sampled when `redirect`=1.
- `mem_addr`  out  16  BRAM port A address; equals the PC register (combinational from it).
- `mem_en`  out  1  BRAM port A enable.
- `mem_rdata`  in  16  BRAM port A read data; holds the word for the address sampled at the previous enabled edge.
- `instr`  out  16  IR contents, to `decoder.instr`.
- `instr_valid`  out  1  IR holds a real fetched word (not a bubble).
- `instr_pc`  out  16  word address of the word in IR.
- `pc_plus1`  out  16  `instr_pc`+1, modulo 2^16; link value for jump-and-link.

## Operation
Internal state:
- `pc`, 16 bits.
- `f_valid`: `mem_rdata` carries a non-squashed fetch.
- `f_pc`: address of the word on `mem_rdata`.
- `ir`, 16 bits; `ir_valid`; `ir_pc`, 16 bits.

Per rising edge, evaluated in priority order:
- **reset**: `pc`<=RESET_PC, `f_valid`<=0, `f_pc`<=0, `ir`<=0, `ir_valid`<=0, `ir_pc`<=0.
- **redirect**: `pc`<=`redirect_pc`, `f_valid`<=0, `ir`<=0, `ir_valid`<=0, `ir_pc` held. The in-flight word and the IR contents are both squashed.
- **stall** (without redirect): all state held.
- **advance**: `pc`<=`pc`+1, `f_valid`<=1, `f_pc`<=`pc`. IR loads `ir`<=`f_valid` ? `mem_rdata` : 16'h0000, `ir_valid`<=`f_valid`, and `ir_pc`<=`f_pc`.

Outputs and width rules:
- `mem_en` = ~`stall` | `redirect` | `reset`. With `mem_en` deasserted during a stall, BRAM keeps `mem_rdata` stable, so no word is lost when the stall releases.
- PC arithmetic is 16-bit, word-addressed, and wraps 16'hFFFF -> 16'h0000 with no flag. `pc_plus1` wraps identically.

Pipeline occupancy, derived from (`f_valid`, `ir_valid`):
- EMPTY (0,0) -> FILL (1,0) on advance.
- FILL -> FULL (1,1) on advance.
- FULL stays FULL on advance.
- Any state -> EMPTY on reset or redirect.
- Stall holds the current state.

Bubble behaviour: when `instr_valid`=0, `instr` is forced to 16'h0000, which `decoder` treats as a NOP R-type. Downstream must also gate register writes with `instr_valid`.

## Timing
- Reset values: `mem_addr`=RESET_PC, `mem_en`=1, `instr`=16'h0000, `instr_valid`=0, `instr_pc`=0, `pc_plus1`=1.
- Latency from address issue to IR is 2 edges. After reset deasserts, the first edge fetches RESET_PC and the second edge places mem[RESET_PC] in IR with `instr_valid`=1.
- Steady state: one instruction per cycle; `instr_pc` increments by 1 each non-stalled cycle.
- Redirect on edge k: IR is a bubble after edges k and k+1; mem[`redirect_pc`] appears after edge k+2, a 2-cycle penalty.
- Stall over N cycles: `instr`, `instr_valid`, `instr_pc` and `mem_addr` are constant for all N cycles. The sequence resumes on the first non-stalled edge with no duplicated or skipped word.
- Simultaneous `redirect` and `stall`: redirect wins; the PC is loaded and the pipeline flushed.
- `redirect` on consecutive cycles: the last target wins and each redirect restarts the 2-bubble count.
- Reset during a stall or redirect: reset wins; the outputs take their reset values on that edge.

## Test plan
- **Straight fetch.** Preload mem[i]=16'h5000+i, RESET_PC=0, release reset. Required: `instr_valid` rises after edge 2 with `instr`=16'h5000, `instr_pc`=0, then 16'h5001, 16'h5002, and so on, one per cycle.
- **Stall.** Assert `stall` for 3 cycles while IR holds 16'h5004. Required: `instr`=16'h5004 and `mem_addr`=6 for all 3 cycles; 16'h5005 follows on the first edge after release.
- **Redirect.** Assert `redirect` with `redirect_pc`=16'h0100 while IR holds 16'h5002; mem[0x100]=16'hA1B2. Required: 2 bubble cycles (`instr`=0, `instr_valid`=0), then `instr`=16'hA1B2, `instr_pc`=16'h0100, `pc_plus1`=16'h0101.
- **Redirect with stall.** Assert `redirect` and `stall` in the same cycle with `redirect_pc`=16'h0020. Required: identical behaviour to redirect alone; `mem_addr`=16'h0020 on the next cycle.
- **Wrap-around.** Redirect to 16'hFFFE with mem[FFFE]=1, mem[FFFF]=2, mem[0]=3. Required: `instr_pc` sequence FFFE, FFFF, 0000; `pc_plus1` for the FFFF entry is 16'h0000.
- **Reset mid-stall.** Assert `reset` while `stall`=1 and the pipeline is FULL. Required: on the next edge `instr_valid`=0, `instr`=0, `mem_addr`=RESET_PC; refill takes 2 cycles after reset deasserts.
